// File: rtl/nibble_serial_adder.sv
// Wide adder front end: streams WIDTH-bit operands nibble by nibble,
// LSB first, through an external 4-bit ripple adder.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int NCHUNK = WIDTH / 4;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [3:0]       a_nib, b_nib;
  logic             last;

  assign last = (idx_q == IW'(NCHUNK - 1));

  // Select the current nibble of each operand register.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = a_nib;
        add_b   = b_nib;
        add_cin = carry_q;
        carry_d = add_cout;
        for (int i = 0; i < NCHUNK; i++) begin
          if (idx_q == IW'(i)) begin
            sum_d[4*i +: 4] = add_sum;
          end
        end
        if (last) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = carry_q;

endmodule
